uart_cmd_decoder: RTL and testbench

Consumes the byte stream from the UART receiver (rx_data / rx_data_valid) and decodes framed host commands. Streams payload bytes into framebuffer memory through a ready/valid write port, and commits checksum-verified single-byte writes to the VGA control register file. Sits between the UART receiver and the framebuffer / control-register blocks.

---
 rtl/uart_cmd_pkg.sv | 31 +++
 rtl/byte_fifo.sv | 56 +++++
 rtl/uart_cmd_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared constants and state encoding for the UART command
//               decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

   localparam logic [7:0] SYNC_BYTE     = 8'hA5;
   localparam logic [7:0] CMD_WRITE_MEM = 8'h01;
   localparam logic [7:0] CMD_WRITE_REG = 8'h02;

   typedef enum logic [2:0] {
      WAIT_SYNC   = 3'd0,
      GET_CMD     = 3'd1,
      GET_ADDR_HI = 3'd2,
      GET_ADDR_LO = 3'd3,
      GET_LEN     = 3'd4,
      GET_DATA    = 3'd5,
      GET_CSUM    = 3'd6,
      FLUSH       = 3'd7
   } cmd_state_t;

   // True for the command codes this decoder understands.
   function automatic logic cmd_known(input logic [7:0] c);
      return (c == CMD_WRITE_MEM) || (c == CMD_WRITE_REG);
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Small synchronous FIFO with first-word fall-through read
//               data (pop_data always shows the head entry).
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // The extra pointer bit distinguishes full from empty when indexes match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = store[rd_ptr[AW-1:0]];

   // Storage array write; contents need no reset because pointers gate reads.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         store[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // Pointer maintenance with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Decodes framed host commands from the UART byte stream,
//               streams WRITE_MEM payload to framebuffer memory and commits
//               checksum-verified WRITE_REG bytes to the control registers.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int TIMEOUT_CLKS = 250000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_data_valid,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wr_data,
   input  logic                  mem_wr_ready,
   output logic                  reg_wr_en,
   output logic [3:0]            reg_addr,
   output logic [7:0]            reg_wr_data,
   output logic                  pkt_ok,
   output logic                  err_checksum,
   output logic                  err_overflow,
   output logic                  err_timeout,
   output logic                  err_cmd,
   output logic                  busy
);

   localparam int TW = $clog2(TIMEOUT_CLKS + 1);

   cmd_state_t      state, state_next;
   logic [7:0]      cmd, addr_hi, csum;
   logic [8:0]      len_total, pay_cnt;
   logic            csum_bad, ovf_seen, sync_pend;
   logic [TW-1:0]   tmo_cnt;
   logic            push_pend;
   logic [7:0]      push_data;
   logic            fifo_full, fifo_empty;
   logic [7:0]      fifo_head;
   logic [15:0]     full_addr;

   logic            in_frame, timeout_hit, flush_done, mem_accept, rx_sync;
   logic            pkt_ok_nx, err_csum_nx, err_cmd_nx, err_tmo_nx, reg_we_nx;

   assign in_frame    = (state != WAIT_SYNC) && (state != FLUSH);
   assign timeout_hit = in_frame && !rx_data_valid && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));
   assign flush_done  = fifo_empty && !push_pend;
   assign rx_sync     = rx_data_valid && (rx_data == SYNC_BYTE);
   assign full_addr   = {addr_hi, rx_data};
   assign busy        = (state != WAIT_SYNC);

   // The FIFO head is the memory request itself, so the buffer holds exactly
   // FIFO_DEPTH bytes and the request stays stable until it is popped.
   assign mem_wr_en   = !fifo_empty;
   assign mem_wr_data = fifo_empty ? 8'h00 : fifo_head;
   assign mem_accept  = mem_wr_en && mem_wr_ready;

   byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_pend),
      .push_data (push_data),
      .pop       (mem_accept),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= WAIT_SYNC;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and packet result pulses (registered below).
   always_comb begin
      state_next  = state;
      pkt_ok_nx   = 1'b0;
      err_csum_nx = 1'b0;
      err_cmd_nx  = 1'b0;
      err_tmo_nx  = 1'b0;
      reg_we_nx   = 1'b0;
      if (timeout_hit) begin
         err_tmo_nx = 1'b1;
         state_next = WAIT_SYNC;
      end else begin
         case (state)
            WAIT_SYNC:   if (rx_sync) state_next = GET_CMD;
            GET_CMD:     if (rx_data_valid) begin
                            if (cmd_known(rx_data)) begin
                               state_next = GET_ADDR_HI;
                            end else begin
                               err_cmd_nx = 1'b1;
                               state_next = WAIT_SYNC;
                            end
                         end
            GET_ADDR_HI: if (rx_data_valid) state_next = GET_ADDR_LO;
            GET_ADDR_LO: if (rx_data_valid) state_next = GET_LEN;
            GET_LEN:     if (rx_data_valid) begin
                            if ((cmd == CMD_WRITE_REG) && (rx_data != 8'd1)) begin
                               err_cmd_nx = 1'b1;
                               state_next = WAIT_SYNC;
                            end else begin
                               state_next = GET_DATA;
                            end
                         end
            GET_DATA:    if (rx_data_valid && ((pay_cnt + 9'd1) == len_total)) state_next = GET_CSUM;
            GET_CSUM:    if (rx_data_valid) state_next = FLUSH;
            FLUSH:       if (flush_done) begin
                            if (csum_bad) begin
                               err_csum_nx = 1'b1;
                            end else if (!ovf_seen) begin
                               pkt_ok_nx = 1'b1;
                               reg_we_nx = (cmd == CMD_WRITE_REG);
                            end
                            state_next = (sync_pend || rx_sync) ? GET_CMD : WAIT_SYNC;
                         end
            default:     state_next = WAIT_SYNC;
         endcase
      end
   end

   // Frame datapath: field capture, checksum, payload staging, timeout and
   // output pulse registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cmd          <= '0;
         addr_hi      <= '0;
         csum         <= '0;
         len_total    <= '0;
         pay_cnt      <= '0;
         csum_bad     <= 1'b0;
         ovf_seen     <= 1'b0;
         sync_pend    <= 1'b0;
         tmo_cnt      <= '0;
         push_pend    <= 1'b0;
         push_data    <= '0;
         mem_addr     <= '0;
         reg_addr     <= '0;
         reg_wr_data  <= '0;
         reg_wr_en    <= 1'b0;
         pkt_ok       <= 1'b0;
         err_checksum <= 1'b0;
         err_overflow <= 1'b0;
         err_timeout  <= 1'b0;
         err_cmd      <= 1'b0;
      end else begin
         reg_wr_en    <= reg_we_nx;
         pkt_ok       <= pkt_ok_nx;
         err_checksum <= err_csum_nx;
         err_timeout  <= err_tmo_nx;
         err_cmd      <= err_cmd_nx;
         push_pend    <= 1'b0;
         err_overflow <= 1'b0;

         tmo_cnt <= (!in_frame || rx_data_valid) ? '0 : tmo_cnt + 1'b1;

         // Byte staged last cycle is pushed now, or dropped if the FIFO is full.
         if (push_pend && fifo_full) begin
            err_overflow <= 1'b1;
            ovf_seen     <= 1'b1;
         end

         if (mem_accept) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
         end

         // A SYNC seen while draining starts the next frame right after FLUSH.
         if ((state == FLUSH) && (state_next != FLUSH)) begin
            sync_pend <= 1'b0;
         end else if ((state == FLUSH) && rx_sync) begin
            sync_pend <= 1'b1;
         end

         if (rx_data_valid) begin
            case (state)
               GET_CMD: begin
                  cmd      <= rx_data;
                  csum     <= rx_data;
                  csum_bad <= 1'b0;
                  ovf_seen <= 1'b0;
               end
               GET_ADDR_HI: begin
                  addr_hi <= rx_data;
                  csum    <= csum ^ rx_data;
               end
               GET_ADDR_LO: begin
                  csum <= csum ^ rx_data;
                  if (cmd == CMD_WRITE_MEM) begin
                     mem_addr <= full_addr[ADDR_WIDTH-1:0];
                  end else begin
                     reg_addr <= rx_data[3:0];
                  end
               end
               GET_LEN: begin
                  csum      <= csum ^ rx_data;
                  len_total <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                  pay_cnt   <= '0;
               end
               GET_DATA: begin
                  csum    <= csum ^ rx_data;
                  pay_cnt <= pay_cnt + 9'd1;
                  if (cmd == CMD_WRITE_MEM) begin
                     push_pend <= 1'b1;
                     push_data <= rx_data;
                  end else begin
                     reg_wr_data <= rx_data;
                  end
               end
               GET_CSUM: begin
                  csum_bad <= (rx_data != csum);
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_decoder
// Description : Directed self-checking bench for uart_cmd_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_data_valid = 1'b0;
   logic        mem_wr_en;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wr_data;
   logic        mem_wr_ready = 1'b1;
   logic        reg_wr_en;
   logic [3:0]  reg_addr;
   logic [7:0]  reg_wr_data;
   logic        pkt_ok, err_checksum, err_overflow, err_timeout, err_cmd, busy;

   uart_cmd_decoder #(
      .ADDR_WIDTH   (16),
      .FIFO_DEPTH   (4),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .mem_wr_en     (mem_wr_en),
      .mem_addr      (mem_addr),
      .mem_wr_data   (mem_wr_data),
      .mem_wr_ready  (mem_wr_ready),
      .reg_wr_en     (reg_wr_en),
      .reg_addr      (reg_addr),
      .reg_wr_data   (reg_wr_data),
      .pkt_ok        (pkt_ok),
      .err_checksum  (err_checksum),
      .err_overflow  (err_overflow),
      .err_timeout   (err_timeout),
      .err_cmd       (err_cmd),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Event counters and write log, maintained only by the monitor.
   int n_ok = 0, n_csum = 0, n_ovf = 0, n_tmo = 0, n_cmd = 0;
   int n_reg = 0, n_reg_ok = 0, stab_viol = 0;
   logic [15:0] wa_q[$];
   logic [7:0]  wd_q[$];
   logic [3:0]  last_ra = '0;
   logic [7:0]  last_rd = '0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_a = '0;
   logic [7:0]  prev_d = '0;

   // Snapshots taken by the stimulus process at the start of each test.
   int s_ok, s_csum, s_ovf, s_tmo, s_cmd, s_reg, s_reg_ok, s_wr;

   logic [7:0] payload[$];

   // Sample outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (pkt_ok)       n_ok++;
      if (err_checksum) n_csum++;
      if (err_overflow) n_ovf++;
      if (err_timeout)  n_tmo++;
      if (err_cmd)      n_cmd++;
      if (reg_wr_en) begin
         n_reg++;
         last_ra = reg_addr;
         last_rd = reg_wr_data;
         if (pkt_ok) n_reg_ok++;
      end
      if (mem_wr_en && mem_wr_ready) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wr_data);
      end
      if (prev_stall && (!mem_wr_en || mem_addr != prev_a || mem_wr_data != prev_d)) stab_viol++;
      prev_stall = mem_wr_en && !mem_wr_ready;
      prev_a     = mem_addr;
      prev_d     = mem_wr_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      s_ok = n_ok; s_csum = n_csum; s_ovf = n_ovf; s_tmo = n_tmo; s_cmd = n_cmd;
      s_reg = n_reg; s_reg_ok = n_reg_ok; s_wr = wa_q.size();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      rx_data = b;
      rx_data_valid = 1'b1;
      @(posedge clk); #1;
      rx_data_valid = 1'b0;
      rx_data = '0;
      repeat (gap) @(posedge clk);
   endtask

   // Sends a full frame using the global payload queue; bad corrupts CSUM.
   task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                             input logic [7:0] len, input bit bad_cs, input int gap);
      logic [7:0] cs;
      cs = cmd ^ addr[15:8] ^ addr[7:0] ^ len;
      send_byte(8'hA5, gap);
      send_byte(cmd, gap);
      send_byte(addr[15:8], gap);
      send_byte(addr[7:0], gap);
      send_byte(len, gap);
      foreach (payload[i]) begin
         cs = cs ^ payload[i];
         send_byte(payload[i], gap);
      end
      send_byte(bad_cs ? ~cs : cs, gap);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int i;
      for (i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      if (i == limit) chk(tag, 32'd1, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_mem_wr_en", mem_wr_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_reg_wr_en", reg_wr_en, 0);
      chk("rst_pkt_ok", pkt_ok, 0);

      // Test 1: WRITE_MEM of three bytes with ready high.
      snap();
      payload = '{8'h11, 8'h22, 8'h33};
      send_frame(8'h01, 16'h1234, 8'd3, 1'b0, 1);
      wait_idle("t1_idle", 200);
      chk("t1_nwr", wa_q.size() - s_wr, 3);
      chk("t1_a0", wa_q[s_wr],   16'h1234); chk("t1_d0", wd_q[s_wr],   8'h11);
      chk("t1_a1", wa_q[s_wr+1], 16'h1235); chk("t1_d1", wd_q[s_wr+1], 8'h22);
      chk("t1_a2", wa_q[s_wr+2], 16'h1236); chk("t1_d2", wd_q[s_wr+2], 8'h33);
      chk("t1_pkt_ok", n_ok - s_ok, 1);
      chk("t1_errs", (n_csum - s_csum) + (n_ovf - s_ovf) + (n_tmo - s_tmo) + (n_cmd - s_cmd), 0);

      // Test 2: WRITE_REG good checksum, then corrupted checksum.
      snap();
      payload = '{8'h5A};
      send_frame(8'h02, 16'h0007, 8'd1, 1'b0, 1);
      wait_idle("t2_idle", 200);
      chk("t2_nreg", n_reg - s_reg, 1);
      chk("t2_reg_addr", last_ra, 4'h7);
      chk("t2_reg_data", last_rd, 8'h5A);
      chk("t2_reg_with_ok", n_reg_ok - s_reg_ok, 1);
      chk("t2_pkt_ok", n_ok - s_ok, 1);
      snap();
      send_frame(8'h02, 16'h0007, 8'd1, 1'b1, 1);
      wait_idle("t2b_idle", 200);
      chk("t2b_err_csum", n_csum - s_csum, 1);
      chk("t2b_nreg", n_reg - s_reg, 0);
      chk("t2b_pkt_ok", n_ok - s_ok, 0);

      // Test 3: backpressure, six bytes into a four-entry buffer.
      snap();
      mem_wr_ready = 1'b0;
      payload = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
      send_frame(8'h01, 16'h0100, 8'd6, 1'b0, 2);
      repeat (10) @(negedge clk);
      chk("t3_ovf", n_ovf - s_ovf, 2);
      chk("t3_nwr_stalled", wa_q.size() - s_wr, 0);
      chk("t3_busy_stalled", busy, 1);
      chk("t3_stable", stab_viol, 0);
      @(posedge clk); #1 mem_wr_ready = 1'b1;
      wait_idle("t3_idle", 200);
      chk("t3_nwr", wa_q.size() - s_wr, 4);
      chk("t3_a0", wa_q[s_wr],   16'h0100); chk("t3_d0", wd_q[s_wr],   8'hA1);
      chk("t3_a3", wa_q[s_wr+3], 16'h0103); chk("t3_d3", wd_q[s_wr+3], 8'hA4);
      chk("t3_pkt_ok", n_ok - s_ok, 0);
      chk("t3_err_csum", n_csum - s_csum, 0);

      // Test 4: timeout mid-header, then a good frame.
      snap();
      send_byte(8'hA5, 1);
      send_byte(8'h01, 1);
      send_byte(8'h00, 0);
      wait_idle("t4_idle", TMO + 40);
      chk("t4_tmo", n_tmo - s_tmo, 1);
      chk("t4_busy", busy, 0);
      snap();
      payload = '{8'h77};
      send_frame(8'h01, 16'h0042, 8'd1, 1'b0, 1);
      wait_idle("t4b_idle", 200);
      chk("t4b_pkt_ok", n_ok - s_ok, 1);
      chk("t4b_a", wa_q[s_wr], 16'h0042);
      chk("t4b_d", wd_q[s_wr], 8'h77);
      chk("t4b_no_tmo", n_tmo - s_tmo, 0);

      // Test 5: unknown command, illegal REG length, leading noise.
      snap();
      send_byte(8'hA5, 1);
      send_byte(8'h07, 1);
      repeat (3) @(negedge clk);
      chk("t5_err_cmd_unknown", n_cmd - s_cmd, 1);
      chk("t5_busy", busy, 0);
      snap();
      send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h00, 1);
      send_byte(8'h03, 1); send_byte(8'h02, 1);
      repeat (3) @(negedge clk);
      chk("t5_err_cmd_len", n_cmd - s_cmd, 1);
      snap();
      send_byte(8'h00, 1);
      send_byte(8'hFF, 1);
      payload = '{8'h3C};
      send_frame(8'h02, 16'h0009, 8'd1, 1'b0, 1);
      wait_idle("t5_idle", 200);
      chk("t5_noise_pkt_ok", n_ok - s_ok, 1);
      chk("t5_noise_reg_addr", last_ra, 4'h9);
      chk("t5_noise_reg_data", last_rd, 8'h3C);

      // Test 6: address wrap, then reset in the middle of GET_DATA.
      snap();
      payload = '{8'hC1, 8'hC2};
      send_frame(8'h01, 16'hFFFF, 8'd2, 1'b0, 1);
      wait_idle("t6_idle", 200);
      chk("t6_nwr", wa_q.size() - s_wr, 2);
      chk("t6_a0", wa_q[s_wr],   16'hFFFF); chk("t6_d0", wd_q[s_wr],   8'hC1);
      chk("t6_a1", wa_q[s_wr+1], 16'h0000); chk("t6_d1", wd_q[s_wr+1], 8'hC2);
      snap();
      mem_wr_ready = 1'b0;
      send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
      send_byte(8'h10, 1); send_byte(8'h04, 1);
      send_byte(8'hD1, 1); send_byte(8'hD2, 1);
      repeat (2) @(negedge clk);
      chk("t6_pre_rst_wr_en", mem_wr_en, 1);
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t6_rst_wr_en", mem_wr_en, 0);
      chk("t6_rst_addr", mem_addr, 0);
      chk("t6_rst_data", mem_wr_data, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_pulses", {reg_wr_en, pkt_ok, err_checksum, err_overflow, err_timeout, err_cmd}, 0);
      chk("t6_rst_fifo_empty", dut.u_fifo.empty, 1);
      @(posedge clk); #1 reset_n = 1'b1; mem_wr_ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6_post_rst_nwr", wa_q.size() - s_wr, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute guard so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
`default_nettype wire
